muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and the HI/LO register pair, beside the single-cycle ALU in the execute stage.
- Accepts R-type funct codes the ALU control does not handle, runs radix-2 shift-add multiply or restoring divide over WIDTH iterations, and holds HI/LO.
- Raises a stall so the hazard logic freezes IF/ID/EX while busy.
- Also serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/muldiv_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with the HI/LO register pair and MFxx/MTxx access.
// Latency: start sampled at E0, WIDTH iterations, sign fix at E0+WIDTH+1; MTxx writes at E0; div-by-zero reports at E0.
// Backpressure: stall holds the EX instruction while the sequencer is not IDLE; a start is only accepted in IDLE.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] md_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic               op_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   mcand_q;   // multiplicand magnitude, or divisor magnitude
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;

  logic               is_mul, is_div, is_mt, is_mf;
  logic               accept, signed_op, a_neg, b_neg, b_zero, last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_trial;
  logic               div_ok;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Decode and operand conditioning
  always_comb begin
    is_mul    = (funct == F_MULT) || (funct == F_MULTU);
    is_div    = (funct == F_DIV)  || (funct == F_DIVU);
    is_mt     = (funct == F_MTHI) || (funct == F_MTLO);
    is_mf     = (funct == F_MFHI) || (funct == F_MFLO);
    accept    = (state_q == S_IDLE) && start && !flush;
    signed_op = !funct[0];
    a_neg     = signed_op && op_a[WIDTH-1];
    b_neg     = signed_op && op_b[WIDTH-1];
    a_mag     = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag     = b_neg ? (~op_b + 1'b1) : op_b;
    b_zero    = (op_b == '0);
    last      = (count_q == CW'(WIDTH - 1));
  end

  // One shift-add / restoring-subtract step per cycle
  always_comb begin
    mul_addend = prod_q[0] ? mcand_q : '0;
    mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, prod_q[WIDTH-1:1]};
    div_shift  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    div_trial  = div_shift - {1'b0, mcand_q};
    div_ok     = !div_trial[WIDTH];
    rem_next   = div_ok ? div_trial : div_shift;
    quo_next   = {quo_q[WIDTH-2:0], div_ok};
    prod_fix   = neg_res_q ? (~prod_q + 1'b1) : prod_q;
    quo_fix    = neg_res_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix    = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && is_mul)                state_d = S_MUL;
        else if (accept && is_div && !b_zero) state_d = S_DIV;
      end
      S_MUL:   state_d = flush ? S_IDLE : (last ? S_FIX : S_MUL);
      S_DIV:   state_d = flush ? S_IDLE : (last ? S_FIX : S_DIV);
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      op_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      mcand_q     <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          count_q <= '0;
          if (accept && is_mul) begin
            op_div_q  <= 1'b0;
            mcand_q   <= a_mag;
            prod_q    <= {{WIDTH{1'b0}}, b_mag};
            neg_res_q <= a_neg ^ b_neg;
          end
          if (accept && is_div) begin
            if (b_zero) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              op_div_q  <= 1'b1;
              mcand_q   <= b_mag;
              rem_q     <= '0;
              quo_q     <= a_mag;
              neg_res_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
            end
          end
          if (accept && funct == F_MTHI) hi <= op_a;
          if (accept && funct == F_MTLO) lo <= op_a;
        end
        S_MUL: begin
          if (flush) begin
            count_q <= '0;
          end else begin
            prod_q  <= mul_next;
            count_q <= count_q + CW'(1);
          end
        end
        S_DIV: begin
          if (flush) begin
            count_q <= '0;
          end else begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
            count_q <= count_q + CW'(1);
          end
        end
        S_FIX: begin
          count_q <= '0;
          if (!flush) begin
            done <= 1'b1;
            if (op_div_q) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: count_q <= '0;
      endcase
    end
  end

  // Any non-IDLE state holds the pipeline; MFxx during busy would read stale HI/LO.
  assign busy      = (state_q != S_IDLE);
  assign stall     = busy || (start && (is_mf || is_mul || is_div || is_mt) && (state_q != S_IDLE));
  assign md_result = (funct == F_MFHI) ? hi : lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO/div_by_zero queued at issue, checked on done.
module tb_muldiv_ctrl;
  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         stall, busy, done, div_by_zero;
  logic [W-1:0] md_result, hi, lo;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .busy(busy),
    .done(done), .div_by_zero(div_by_zero), .md_result(md_result),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sr;
    longint unsigned ua, ub, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (f)
      F_MULT:  begin sr = sa * sb; return sr; end
      F_MULTU: begin ur = ua * ub; return ur; end
      F_DIV:   return {32'(sa % sb), 32'(sa / sb)};
      default: return {a % b, a / b};
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input logic dbz);
    sb_q.push_back('{eh, el, dbz});
    cur_hi = eh;
    cur_lo = el;
  endtask

  // Monitor: every done must match the oldest queued expectation.
  initial begin
    forever begin
      tick();
      if (done) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_done", done, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("sb_hi", hi, mon_e.hi);
          check_val("sb_lo", lo, mon_e.lo);
          check_val("sb_dbz", div_by_zero, mon_e.dbz);
        end
      end else begin
        check_val("dbz_without_done", div_by_zero, 0);
      end
    end
  end

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_hl);
    int n;
    push_exp(exp_hl[63:32], exp_hl[31:0], 1'b0);
    funct = f; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("stall_while_busy", stall, 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check_val("busy_cycles", n, 33);
    check_val("done_set", done, 1);
    tick();
    check_val("done_pulse_end", done, 0);
  endtask

  task automatic mt_write(input logic [5:0] f, input logic [31:0] a);
    funct = f; op_a = a; start = 1'b1;
    #1;
    check_val("mt_no_stall", stall, 0);
    tick();
    start = 1'b0;
  endtask

  initial begin
    int         n;
    logic [5:0] f;
    logic [31:0] a, b;
    logic [5:0] fsel[4];

    fsel[0] = F_MULT; fsel[1] = F_MULTU; fsel[2] = F_DIV; fsel[3] = F_DIVU;

    repeat (2) tick();
    check_val("rst_hi", hi, 0);
    check_val("rst_lo", lo, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_stall", stall, 0);
    check_val("rst_done", done, 0);
    reset_n = 1'b1;
    tick();

    run_op(F_MULT,  32'd7,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op(F_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op(F_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
    run_op(F_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E);
    run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

    for (int i = 0; i < 6; i++) begin
      f = fsel[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      if (i[0]) b = b >> $urandom_range(8, 28);
      if (b == 0) b = 32'd3;
      run_op(f, a, b, model(f, a, b));
    end

    // MTHI/MTLO, then divide by zero leaves HI/LO alone
    mt_write(F_MTHI, 32'h11);
    mt_write(F_MTLO, 32'h22);
    check_val("mthi", hi, 32'h11);
    check_val("mtlo", lo, 32'h22);
    push_exp(32'h11, 32'h22, 1'b1);
    funct = F_DIVU; op_a = 32'd5; op_b = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("dbz_no_busy", busy, 0);
    tick();
    check_val("dbz_busy_later", busy, 0);
    check_val("dbz_done_clear", done, 0);
    funct = F_MFHI; start = 1'b1;
    #1;
    check_val("mfhi_result", md_result, 32'h11);
    tick();
    start = 1'b0;

    // MFLO presented at cycle 10 of a MULT waits out the operation
    a = 32'h0001_2345; b = 32'hFFFF_8765;
    push_exp(model(F_MULT, a, b) >> 32, model(F_MULT, a, b), 1'b0);
    funct = F_MULT; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    funct = F_MFLO; start = 1'b1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick();
    end
    check_val("mflo_stall_cycles", n, 24);
    check_val("mflo_result", md_result, cur_lo);
    tick();
    start = 1'b0;

    // Flush at cycle 5 of a DIV
    funct = F_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush_idle", busy, 0);
    check_val("flush_hi", hi, cur_hi);
    check_val("flush_lo", lo, cur_lo);
    repeat (40) tick();

    // Flush in IDLE suppresses an MTLO
    funct = F_MTLO; op_a = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check_val("flush_mtlo", lo, cur_lo);

    // Recovers after flush
    run_op(F_DIVU, 32'd1000, 32'd3, 64'h0000_0001_0000_014D);

    // Async reset at cycle 20 of a MULT
    funct = F_MULT; op_a = 32'd12345; op_b = 32'd678; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset_n = 1'b0;
    #1;
    check_val("arst_hi", hi, 0);
    check_val("arst_lo", lo, 0);
    check_val("arst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
    repeat (40) tick();
    check_val("post_rst_lo", lo, 0);
    check_val("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
